// File: rtl/iq_acc_pkg.sv
// Shared widths, window state encoding and the per-point result record
// for the I/Q point accumulator.
package iq_acc_pkg;

  localparam int IQ_DATA_W = 16;
  localparam int IQ_ACC_W  = 48;
  localparam int IQ_CNT_W  = 32;

  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  // Window state is simply the registered trigger.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  typedef struct packed {
    logic signed [IQ_ACC_W-1:0] sum_i;
    logic signed [IQ_ACC_W-1:0] sum_q;
    logic        [IQ_CNT_W-1:0] count;
    logic        [IQ_CNT_W-1:0] index;
  } iq_result_t;

endpackage

// File: rtl/iq_point_accumulator_acc_lane.sv
// One signed accumulation lane: sign-extends a sample and either restarts
// the sum with it or adds it onto the running sum (two's complement wrap).
module acc_lane
  import iq_acc_pkg::*;
#(
  parameter int DATA_W = IQ_DATA_W,
  parameter int ACC_W  = IQ_ACC_W
) (
  input  logic                     aclk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     add,
  input  logic signed [DATA_W-1:0] sample,
  output logic signed [ACC_W-1:0]  sum
);

  logic signed [ACC_W-1:0] sample_ext;

  assign sample_ext = {{(ACC_W-DATA_W){sample[DATA_W-1]}}, sample};

  // A start discards whatever partial sum was left from an aborted window.
  always_ff @(posedge aclk) begin
    if (!rst) begin
      sum <= '0;
    end else if (start) begin
      sum <= add ? sample_ext : '0;
    end else if (add) begin
      sum <= sum + sample_ext;
    end
  end

endmodule

// File: rtl/iq_point_accumulator.sv
// Integrates I/Q samples over each trigger-high window and presents one
// result per window on a valid/ready output, counting results it had to drop.
module iq_point_accumulator
  import iq_acc_pkg::*;
#(
  parameter int DATA_W = IQ_DATA_W,
  parameter int ACC_W  = IQ_ACC_W,
  parameter int CNT_W  = IQ_CNT_W
) (
  input  logic                     aclk,
  input  logic                     rst,
  input  logic                     acc_trigger,
  input  logic                     s_valid,
  input  logic signed [DATA_W-1:0] s_i,
  input  logic signed [DATA_W-1:0] s_q,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [ACC_W-1:0]  m_sum_i,
  output logic signed [ACC_W-1:0]  m_sum_q,
  output logic        [CNT_W-1:0]  m_count,
  output logic        [CNT_W-1:0]  m_index,
  output logic                     overrun,
  output logic        [15:0]       drop_count
);

  logic [0:0]              trig_d;
  logic                    win_start;
  logic                    win_body;
  logic                    win_end;
  logic                    sample_add;
  logic                    slot_free;
  logic                    load;
  logic                    drop;
  logic signed [ACC_W-1:0] sum_i;
  logic signed [ACC_W-1:0] sum_q;
  logic        [CNT_W-1:0] cnt;
  logic        [CNT_W-1:0] idx;

  assign win_start  = acc_trigger  && (trig_d == ST_IDLE);
  assign win_body   = acc_trigger  && (trig_d == ST_ACCUM);
  assign win_end    = !acc_trigger && (trig_d == ST_ACCUM);
  assign sample_add = acc_trigger && s_valid;

  // The slot counts as free when it is being accepted on this same edge.
  assign slot_free = !m_valid || m_ready;
  assign load      = win_end && slot_free;
  assign drop      = win_end && !slot_free;

  always_ff @(posedge aclk) begin
    if (!rst) begin
      trig_d <= ST_IDLE;
    end else begin
      trig_d <= acc_trigger ? ST_ACCUM : ST_IDLE;
    end
  end

  acc_lane #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_lane_i (
    .aclk   (aclk),
    .rst    (rst),
    .start  (win_start),
    .add    (sample_add),
    .sample (s_i),
    .sum    (sum_i)
  );

  acc_lane #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_lane_q (
    .aclk   (aclk),
    .rst    (rst),
    .start  (win_start),
    .add    (sample_add),
    .sample (s_q),
    .sum    (sum_q)
  );

  // Sample count saturates; the sums keep wrapping independently.
  always_ff @(posedge aclk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (win_start) begin
      cnt <= {{(CNT_W-1){1'b0}}, s_valid};
    end else if (win_body && s_valid && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!rst) begin
      idx <= '0;
    end else if (win_end) begin
      idx <= idx + CNT_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!rst) begin
      m_valid <= 1'b0;
      m_sum_i <= '0;
      m_sum_q <= '0;
      m_count <= '0;
      m_index <= '0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_sum_i <= sum_i;
      m_sum_q <= sum_q;
      m_count <= cnt;
      m_index <= idx;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!rst) begin
      overrun    <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overrun <= 1'b1;
      if (drop_count != DROP_MAX) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_iq_point_accumulator.sv
// Self-checking bench for iq_point_accumulator: directed scenarios plus a
// randomized run against a per-window arithmetic model of the result slot.
module tb_iq_point_accumulator;
  import iq_acc_pkg::*;

  localparam int DW = 16;
  localparam int AW = 48;
  localparam int CW = 32;

  logic                 aclk = 1'b0;
  logic                 rst = 1'b0;
  logic                 acc_trigger = 1'b0;
  logic                 s_valid = 1'b0;
  logic                 m_ready = 1'b0;
  logic signed [DW-1:0] s_i = '0;
  logic signed [DW-1:0] s_q = '0;

  logic                 m_valid;
  logic signed [AW-1:0] m_sum_i;
  logic signed [AW-1:0] m_sum_q;
  logic        [CW-1:0] m_count;
  logic        [CW-1:0] m_index;
  logic                 overrun;
  logic        [15:0]   drop_count;

  logic                 n_valid;
  logic signed [AW-1:0] n_sum_i;
  logic signed [AW-1:0] n_sum_q;
  logic        [15:0]   n_count;
  logic        [15:0]   n_index;
  logic                 n_overrun;
  logic        [15:0]   n_drop_count;

  int vectors = 0;
  int miscompares = 0;

  logic       mdl_trig_d;
  longint     win_sum_i;
  longint     win_sum_q;
  longint     win_n;
  longint     point_idx;
  logic       exp_valid;
  iq_result_t exp_res;
  logic       exp_overrun;
  int         exp_drops;

  iq_point_accumulator dut (
    .aclk        (aclk),
    .rst         (rst),
    .acc_trigger (acc_trigger),
    .s_valid     (s_valid),
    .s_i         (s_i),
    .s_q         (s_q),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_sum_i     (m_sum_i),
    .m_sum_q     (m_sum_q),
    .m_count     (m_count),
    .m_index     (m_index),
    .overrun     (overrun),
    .drop_count  (drop_count)
  );

  iq_point_accumulator #(.CNT_W(16)) dut16 (
    .aclk        (aclk),
    .rst         (rst),
    .acc_trigger (acc_trigger),
    .s_valid     (s_valid),
    .s_i         (s_i),
    .s_q         (s_q),
    .m_valid     (n_valid),
    .m_ready     (m_ready),
    .m_sum_i     (n_sum_i),
    .m_sum_q     (n_sum_q),
    .m_count     (n_count),
    .m_index     (n_index),
    .overrun     (n_overrun),
    .drop_count  (n_drop_count)
  );

  always #5 aclk = ~aclk;

  function automatic logic [AW-1:0] wrap_acc(input longint v);
    return v[AW-1:0];
  endfunction

  task automatic model_reset();
    mdl_trig_d  = 1'b0;
    win_sum_i   = 0;
    win_sum_q   = 0;
    win_n       = 0;
    point_idx   = 0;
    exp_valid   = 1'b0;
    exp_res     = '0;
    exp_overrun = 1'b0;
    exp_drops   = 0;
  endtask

  // Window sums are kept unbounded; wrap and saturation apply only when presented.
  task automatic model_update();
    longint cnt_max;
    cnt_max = 64'hFFFF_FFFF;
    if (!rst) begin
      model_reset();
    end else begin
      if (acc_trigger && !mdl_trig_d) begin
        win_sum_i = s_valid ? longint'(s_i) : 0;
        win_sum_q = s_valid ? longint'(s_q) : 0;
        win_n     = s_valid ? 1 : 0;
      end else if (acc_trigger && s_valid) begin
        win_sum_i += longint'(s_i);
        win_sum_q += longint'(s_q);
        win_n     += 1;
      end
      if (!acc_trigger && mdl_trig_d) begin
        if (!exp_valid || m_ready) begin
          exp_valid     = 1'b1;
          exp_res.sum_i = wrap_acc(win_sum_i);
          exp_res.sum_q = wrap_acc(win_sum_q);
          exp_res.count = (win_n > cnt_max) ? '1 : CW'(win_n);
          exp_res.index = CW'(point_idx);
        end else begin
          exp_overrun = 1'b1;
          if (exp_drops < 65535) exp_drops++;
        end
        point_idx++;
      end else if (exp_valid && m_ready) begin
        exp_valid = 1'b0;
      end
      mdl_trig_d = acc_trigger;
    end
  endtask

  task automatic step(input logic trig, input logic sv, input logic signed [DW-1:0] si,
                      input logic signed [DW-1:0] sq, input logic rdy);
    acc_trigger = trig;
    s_valid     = sv;
    s_i         = si;
    s_q         = sq;
    m_ready     = rdy;
    @(posedge aclk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) step(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
    vectors++;
    if (m_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_m_valid: got %0b expected 0", m_valid); end
    vectors++;
    if (m_sum_i !== '0 || m_sum_q !== '0) begin miscompares++; $display("[TB] FAIL reset_sums: got %0d/%0d expected 0/0", m_sum_i, m_sum_q); end
    vectors++;
    if (m_count !== '0 || m_index !== '0) begin miscompares++; $display("[TB] FAIL reset_count_index: got %0d/%0d expected 0/0", m_count, m_index); end
    vectors++;
    if (overrun !== 1'b0 || drop_count !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_overrun: got %0b/%0d expected 0/0", overrun, drop_count); end
    rst = 1'b1;
  endtask

  task automatic test_basic_window();
    step(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 16'sd100, -16'sd3, 1'b0);
    vectors++;
    if (m_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_early_valid: got %0b expected 0", m_valid); end
    step(1'b0, 1'b1, 16'sd555, 16'sd555, 1'b0);
    vectors++;
    if (m_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_latency: got %0b expected 1", m_valid); end
    vectors++;
    if (m_sum_i !== 48'sd800 || m_sum_q !== -48'sd24) begin miscompares++; $display("[TB] FAIL basic_sums: got %0d/%0d expected 800/-24", m_sum_i, m_sum_q); end
    vectors++;
    if (m_count !== 32'd8 || m_index !== 32'd0) begin miscompares++; $display("[TB] FAIL basic_count_index: got %0d/%0d expected 8/0", m_count, m_index); end
    step(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b0);
    vectors++;
    if (m_valid !== 1'b1 || m_sum_i !== 48'sd800) begin miscompares++; $display("[TB] FAIL basic_hold: got %0b/%0d expected 1/800", m_valid, m_sum_i); end
    step(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b1);
    vectors++;
    if (m_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_accept: got %0b expected 0", m_valid); end
  endtask

  task automatic test_toggle_valid();
    for (int k = 0; k < 8; k++) step(1'b1, (k % 2) == 0, 16'sd100, -16'sd3, 1'b1);
    step(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b0);
    vectors++;
    if (m_count !== 32'd4 || m_sum_i !== 48'sd400 || m_sum_q !== -48'sd12) begin
      miscompares++; $display("[TB] FAIL toggle_window: got cnt %0d sum %0d/%0d expected 4 400/-12", m_count, m_sum_i, m_sum_q);
    end
    vectors++;
    if (m_index !== 32'd1) begin miscompares++; $display("[TB] FAIL toggle_index: got %0d expected 1", m_index); end
    step(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b1);
  endtask

  task automatic test_overrun();
    longint idx0;
    idx0 = point_idx;
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 16'(w + 1), 16'sd2, 1'b0);
      step(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b0);
    end
    vectors++;
    if (m_valid !== 1'b1 || m_sum_i !== 48'sd4 || m_index !== CW'(idx0)) begin
      miscompares++; $display("[TB] FAIL overrun_held: got v%0b sum %0d idx %0d expected v1 sum 4 idx %0d", m_valid, m_sum_i, m_index, idx0);
    end
    vectors++;
    if (overrun !== 1'b1 || drop_count !== 16'd2) begin
      miscompares++; $display("[TB] FAIL overrun_flags: got %0b/%0d expected 1/2", overrun, drop_count);
    end
    step(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b1);
    for (int k = 0; k < 2; k++) step(1'b1, 1'b1, 16'sd3, 16'sd3, 1'b1);
    step(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b1);
    vectors++;
    if (m_valid !== 1'b1 || m_index !== CW'(idx0 + 3) || overrun !== 1'b1) begin
      miscompares++; $display("[TB] FAIL overrun_next_index: got v%0b idx %0d ovr %0b expected v1 idx %0d ovr 1", m_valid, m_index, overrun, idx0 + 3);
    end
    step(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [15:0] drops0;
    drops0 = drop_count;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 16'sd5, 16'sd1, 1'b0);
    step(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b0);
    step(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b0);
    for (int k = 0; k < 2; k++) step(1'b1, 1'b1, 16'sd9, -16'sd9, 1'b0);
    step(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b1);
    vectors++;
    if (m_valid !== 1'b1 || m_sum_i !== 48'sd18 || m_sum_q !== -48'sd18 || m_count !== 32'd2) begin
      miscompares++; $display("[TB] FAIL b2b_reload: got v%0b sum %0d/%0d cnt %0d expected v1 18/-18 cnt 2", m_valid, m_sum_i, m_sum_q, m_count);
    end
    vectors++;
    if (drop_count !== drops0) begin miscompares++; $display("[TB] FAIL b2b_no_drop: got %0d expected %0d", drop_count, drops0); end
    for (int k = 0; k < 2; k++) step(1'b1, 1'b1, 16'sd1, 16'sd0, 1'b1);
    step(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b1);
    vectors++;
    if (m_valid !== 1'b1 || m_sum_i !== 48'sd2 || m_count !== 32'd2) begin
      miscompares++; $display("[TB] FAIL gap1_first: got v%0b sum %0d cnt %0d expected v1 2 cnt 2", m_valid, m_sum_i, m_count);
    end
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 16'sd2, 16'sd0, 1'b1);
    step(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b1);
    vectors++;
    if (m_valid !== 1'b1 || m_sum_i !== 48'sd6 || m_count !== 32'd3) begin
      miscompares++; $display("[TB] FAIL gap1_second: got v%0b sum %0d cnt %0d expected v1 6 cnt 3", m_valid, m_sum_i, m_count);
    end
    step(1'b1, 1'b0, 16'sd77, 16'sd77, 1'b1);
    step(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b1);
    vectors++;
    if (m_valid !== 1'b1 || m_sum_i !== 48'sd0 || m_count !== 32'd0) begin
      miscompares++; $display("[TB] FAIL pulse_empty: got v%0b sum %0d cnt %0d expected v1 0 cnt 0", m_valid, m_sum_i, m_count);
    end
    step(1'b1, 1'b1, -16'sd77, 16'sd11, 1'b1);
    step(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b1);
    vectors++;
    if (m_valid !== 1'b1 || m_sum_i !== -48'sd77 || m_sum_q !== 48'sd11 || m_count !== 32'd1) begin
      miscompares++; $display("[TB] FAIL pulse_one: got v%0b sum %0d/%0d cnt %0d expected v1 -77/11 cnt 1", m_valid, m_sum_i, m_sum_q, m_count);
    end
    step(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b1);
  endtask

  task automatic test_random();
    logic trig;
    trig = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) == 0) trig = ~trig;
      step(trig, 1'($urandom), 16'($urandom), 16'($urandom), $urandom_range(2) != 0);
      vectors++;
      if (m_valid !== exp_valid || overrun !== exp_overrun || drop_count !== 16'(exp_drops) ||
          (exp_valid && ({m_sum_i, m_sum_q, m_count, m_index} !== exp_res))) begin
        miscompares++;
        $display("[TB] FAIL random_cycle%0d: got v%0b %0d/%0d c%0d i%0d o%0b d%0d expected v%0b %0d/%0d c%0d i%0d o%0b d%0d",
                 c, m_valid, m_sum_i, m_sum_q, m_count, m_index, overrun, drop_count,
                 exp_valid, exp_res.sum_i, exp_res.sum_q, exp_res.count, exp_res.index, exp_overrun, exp_drops);
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [AW-1:0] exp_big;
    exp_big = -48'sd2293760000;
    step(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b1);
    step(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b1);
    for (int k = 0; k < 70000; k++) step(1'b1, 1'b1, -16'sd32768, 16'sd0, 1'b1);
    step(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b1);
    vectors++;
    if (m_valid !== 1'b1 || m_sum_i !== exp_big || m_count !== 32'd70000) begin
      miscompares++; $display("[TB] FAIL long_window: got v%0b sum %0d cnt %0d expected v1 %0d cnt 70000", m_valid, m_sum_i, m_count, exp_big);
    end
    vectors++;
    if (n_valid !== 1'b1 || n_sum_i !== exp_big || n_count !== 16'hFFFF) begin
      miscompares++; $display("[TB] FAIL cnt16_saturate: got v%0b sum %0d cnt %0d expected v1 %0d cnt 65535", n_valid, n_sum_i, n_count, exp_big);
    end
    step(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b1);
  endtask

  task automatic test_reset_mid_window();
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 16'sd50, 16'sd50, 1'b1);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) step(1'b1, 1'b1, 16'sd50, 16'sd50, 1'b1);
    vectors++;
    if (m_valid !== 1'b0 || m_sum_i !== '0 || m_index !== '0 || overrun !== 1'b0 || drop_count !== 16'd0) begin
      miscompares++; $display("[TB] FAIL midreset_outputs: got v%0b sum %0d idx %0d o%0b d%0d expected all 0", m_valid, m_sum_i, m_index, overrun, drop_count);
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 16'sd7, -16'sd7, 1'b1);
    step(1'b0, 1'b0, 16'sd0, 16'sd0, 1'b1);
    vectors++;
    if (m_valid !== 1'b1 || m_sum_i !== 48'sd21 || m_sum_q !== -48'sd21 || m_count !== 32'd3 || m_index !== 32'd0) begin
      miscompares++; $display("[TB] FAIL midreset_next_point: got v%0b %0d/%0d c%0d i%0d expected v1 21/-21 c3 i0", m_valid, m_sum_i, m_sum_q, m_count, m_index);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_window();
    test_toggle_valid();
    test_overrun();
    test_back_to_back();
    test_random();
    test_saturation();
    test_reset_mid_window();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
